// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file types and constants for the write-back path.
// Every block that touches register-file writes imports this package.
package regfile_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    // Writes to the hardwired zero register carry no architectural effect.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return a != REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer handshakes, register-file write port and bypass lookup of the
// write-back queue, bundled so the top and its user share one definition.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4
);
    import regfile_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;

    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic          rw;
    logic [AW-1:0] addr3;
    logic [DW-1:0] wdata;

    logic [AW-1:0] byp_addr1;
    logic [AW-1:0] byp_addr2;
    logic          byp_hit1;
    logic [DW-1:0] byp_data1;
    logic          byp_hit2;
    logic [DW-1:0] byp_data2;

    logic [CW-1:0] count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  byp_addr1, byp_addr2,
        output alu_ready, ld_ready,
        output rw, addr3, wdata,
        output byp_hit1, byp_data1, byp_hit2, byp_data2,
        output count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output byp_addr1, byp_addr2,
        input  alu_ready, ld_ready,
        input  rw, addr3, wdata,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2,
        input  count
    );

endinterface

// File: rtl/regfile_wb_queue_fifo.sv
// In-order FIFO of write-back entries; all slots and their valid bits are
// visible so the owner can search pending writes.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  wb_entry_t                   i_din,
    input  logic                        i_pop,
    output wb_entry_t                   o_head,
    output wb_entry_t [DEPTH-1:0]       o_entries,
    output logic      [DEPTH-1:0]       o_slot_vld,
    output logic      [PW-1:0]          o_rd_ptr,
    output logic      [CW-1:0]          o_count,
    output logic                        o_full,
    output logic                        o_empty
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic      [PW-1:0]    r_wr_ptr;
    logic      [PW-1:0]    r_rd_ptr;
    logic      [CW-1:0]    r_count;

    logic w_full, w_empty, w_push, w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // Storage carries no reset: slot validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] w_age;
        assign w_age         = PW'(g) - r_rd_ptr;
        assign o_slot_vld[g] = CW'(w_age) < r_count;
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register file's single write port from the
// ALU and load unit, with a newest-first bypass lookup for decode.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_wb_queue_if.slave wb
);

    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic      [DEPTH-1:0] w_slot_vld;
    logic      [PW-1:0]    w_rd_ptr;
    logic      [CW-1:0]    w_count;
    logic                  w_full, w_empty;

    logic          r_rw;
    logic [AW-1:0] r_addr3;
    logic [DW-1:0] r_wdata;

    logic      w_ld_fire, w_alu_fire, w_push;
    wb_entry_t w_push_entry;
    logic [DW:0] w_byp1, w_byp2;

    // Load wins over ALU; readiness looks only at occupancy before the edge.
    assign wb.ld_ready  = !w_full;
    assign wb.alu_ready = !w_full && !wb.ld_valid;

    assign w_ld_fire  = wb.ld_valid && !w_full;
    assign w_alu_fire = wb.alu_valid && !w_full && !wb.ld_valid;

    assign w_push_entry = w_ld_fire ? '{addr: wb.ld_addr,  data: wb.ld_data}
                                    : '{addr: wb.alu_addr, data: wb.alu_data};
    assign w_push = (w_ld_fire  && addr_live(wb.ld_addr)) ||
                    (w_alu_fire && addr_live(wb.alu_addr));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_din      (w_push_entry),
        .i_pop      (!w_empty),
        .o_head     (w_head),
        .o_entries  (w_entries),
        .o_slot_vld (w_slot_vld),
        .o_rd_ptr   (w_rd_ptr),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw    <= 1'b0;
            r_addr3 <= '0;
            r_wdata <= '0;
        end else begin
            r_rw <= !w_empty;
            if (!w_empty) begin
                r_addr3 <= w_head.addr;
                r_wdata <= w_head.data;
            end
        end
    end

    // Walk oldest to newest so the youngest match overrides; the output
    // register is considered first and therefore has the lowest priority.
    function automatic logic [DW:0] lookup(
        input logic [AW-1:0]       a,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]    vld,
        input logic [PW-1:0]       rp,
        input logic                orw,
        input logic [AW-1:0]       oa,
        input logic [DW-1:0]       od
    );
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        if (orw && oa == a && addr_live(a)) res = {1'b1, od};
        for (int k = 0; k < DEPTH; k++) begin
            idx = rp + PW'(k);
            if (vld[idx] && ents[idx].addr == a && addr_live(a))
                res = {1'b1, ents[idx].data};
        end
        return res;
    endfunction

    assign w_byp1 = lookup(wb.byp_addr1, w_entries, w_slot_vld, w_rd_ptr,
                           r_rw, r_addr3, r_wdata);
    assign w_byp2 = lookup(wb.byp_addr2, w_entries, w_slot_vld, w_rd_ptr,
                           r_rw, r_addr3, r_wdata);

    assign {wb.byp_hit1, wb.byp_data1} = w_byp1;
    assign {wb.byp_hit2, wb.byp_data2} = w_byp2;

    assign wb.rw    = r_rw;
    assign wb.addr3 = r_addr3;
    assign wb.wdata = r_wdata;
    assign wb.count = w_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against a queue-level model.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();
    regfile_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .wb(bus));

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every register-file write seen in mid-cycle.
    logic [AW+DW-1:0] obs_q[$];
    always @(negedge clk) if (rst_n && bus.rw) obs_q.push_back({bus.addr3, bus.wdata});

    task automatic drive(input bit ldv, input logic [AW-1:0] lda, input logic [DW-1:0] ldd,
                         input bit aluv, input logic [AW-1:0] ala, input logic [DW-1:0] ald,
                         input logic [AW-1:0] b1, input logic [AW-1:0] b2);
        bus.ld_valid = ldv;  bus.ld_addr = lda;  bus.ld_data = ldd;
        bus.alu_valid = aluv; bus.alu_addr = ala; bus.alu_data = ald;
        bus.byp_addr1 = b1;  bus.byp_addr2 = b2;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, '0, '0, '0, '0);
    endtask

    typedef struct {
        bit ldv; logic [AW-1:0] lda; logic [DW-1:0] ldd;
        bit aluv; logic [AW-1:0] ala; logic [DW-1:0] ald;
        logic [AW-1:0] ba;
        bit e_ldr; bit e_alur; int e_cnt;
        bit e_rw; logic [AW-1:0] e_a3; logic [DW-1:0] e_wd;
        bit e_hit; logic [DW-1:0] e_bd;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit ldv, input logic [AW-1:0] lda, input logic [DW-1:0] ldd,
                       input bit aluv, input logic [AW-1:0] ala, input logic [DW-1:0] ald,
                       input logic [AW-1:0] ba, input bit e_ldr, input bit e_alur, input int e_cnt,
                       input bit e_rw, input logic [AW-1:0] e_a3, input logic [DW-1:0] e_wd,
                       input bit e_hit, input logic [DW-1:0] e_bd);
        vec_t v;
        v.ldv = ldv; v.lda = lda; v.ldd = ldd; v.aluv = aluv; v.ala = ala; v.ald = ald;
        v.ba = ba; v.e_ldr = e_ldr; v.e_alur = e_alur; v.e_cnt = e_cnt;
        v.e_rw = e_rw; v.e_a3 = e_a3; v.e_wd = e_wd; v.e_hit = e_hit; v.e_bd = e_bd;
        vt.push_back(v);
    endtask

    // Reference model: pending writes in acceptance order plus the output register.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t mq[$];
    bit m_rw; logic [AW-1:0] m_a3; logic [DW-1:0] m_wd;

    function automatic logic [DW:0] m_lookup(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == a) return {1'b1, mq[i].d};
        if (m_rw && m_a3 == a) return {1'b1, m_wd};
        return '0;
    endfunction

    initial begin
        logic [AW+DW-1:0] exp_w[$];
        rst_n = 1'b0;
        idle();
        #12;
        check("rst_rw", bus.rw, 0);
        check("rst_addr3", bus.addr3, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_count", bus.count, 0);
        check("rst_hit", bus.byp_hit1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write
        add(0,0,0, 1,5,32'hDEADBEEF, 5, 1,1,1, 0,0,0, 1,32'hDEADBEEF);
        add(0,0,0, 0,0,0,            5, 1,1,0, 1,5,32'hDEADBEEF, 1,32'hDEADBEEF);
        add(0,0,0, 0,0,0,            5, 1,1,0, 0,0,0, 0,0);
        // Contention: load first, ALU held valid
        add(1,3,32'h11, 1,4,32'h22,  3, 1,0,1, 0,0,0, 1,32'h11);
        add(0,0,0,      1,4,32'h22,  4, 1,1,1, 1,3,32'h11, 1,32'h22);
        add(0,0,0,      0,0,0,       4, 1,1,0, 1,4,32'h22, 1,32'h22);
        add(0,0,0,      0,0,0,       4, 1,1,0, 0,0,0, 0,0);
        // Zero register
        add(0,0,0, 1,0,32'h55, 0, 1,1,0, 0,0,0, 0,0);
        add(0,0,0, 0,0,0,      0, 1,1,0, 0,0,0, 0,0);
        // Bypass newest
        add(0,0,0, 1,7,32'hA, 7, 1,1,1, 0,0,0, 1,32'hA);
        add(0,0,0, 1,7,32'hB, 7, 1,1,1, 1,7,32'hA, 1,32'hB);
        add(0,0,0, 0,0,0,     7, 1,1,0, 1,7,32'hB, 1,32'hB);
        add(0,0,0, 0,0,0,     7, 1,1,0, 0,0,0, 0,0);

        foreach (vt[i]) begin
            drive(vt[i].ldv, vt[i].lda, vt[i].ldd, vt[i].aluv, vt[i].ala, vt[i].ald, vt[i].ba, vt[i].ba);
            #1;
            check($sformatf("v%0d_ld_ready", i), bus.ld_ready, vt[i].e_ldr);
            check($sformatf("v%0d_alu_ready", i), bus.alu_ready, vt[i].e_alur);
            @(posedge clk); #1;
            check($sformatf("v%0d_count", i), bus.count, vt[i].e_cnt);
            check($sformatf("v%0d_rw", i), bus.rw, vt[i].e_rw);
            if (vt[i].e_rw) begin
                check($sformatf("v%0d_addr3", i), bus.addr3, vt[i].e_a3);
                check($sformatf("v%0d_wdata", i), bus.wdata, vt[i].e_wd);
            end
            check($sformatf("v%0d_hit1", i), bus.byp_hit1, vt[i].e_hit);
            check($sformatf("v%0d_data1", i), bus.byp_data1, vt[i].e_bd);
            check($sformatf("v%0d_hit2", i), bus.byp_hit2, vt[i].e_hit);
            check($sformatf("v%0d_data2", i), bus.byp_data2, vt[i].e_bd);
        end

        // Six back-to-back loads: drain keeps pace, so the queue never fills.
        idle(); @(posedge clk); #1;
        obs_q.delete(); exp_w.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1, AW'(10 + i), 32'h100 + i, 0, '0, '0, '0, '0);
            exp_w.push_back({AW'(10 + i), 32'h100 + i});
            #1;
            check($sformatf("b2b%0d_ld_ready", i), bus.ld_ready, 1);
            @(posedge clk); #1;
            check($sformatf("b2b%0d_count", i), bus.count, 1);
        end
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("b2b_nwrites", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            check($sformatf("b2b_order%0d", i), obs_q[i], exp_w[i]);

        // Reset asserted between edges with writes in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, AW'(20 + i), 32'h200 + i, 0, '0, '0, AW'(22), AW'(21));
            @(posedge clk); #1;
        end
        check("pre_rst_hit1", bus.byp_hit1, 1);
        check("pre_rst_hit2", bus.byp_hit2, 1);
        #2;
        idle(); bus.byp_addr1 = AW'(22); bus.byp_addr2 = AW'(21);
        rst_n = 1'b0;
        obs_q.delete();
        #1;
        check("async_rw", bus.rw, 0);
        check("async_count", bus.count, 0);
        check("async_hit1", bus.byp_hit1, 0);
        check("async_hit2", bus.byp_hit2, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_writes", obs_q.size(), 0);

        // Random traffic against the model; small address set forces collisions.
        mq.delete(); m_rw = 0; m_a3 = '0; m_wd = '0;
        for (int c = 0; c < 400; c++) begin
            bit ldv, aluv, full, ldf, aluf;
            logic [AW-1:0] la, aa, b1, b2;
            logic [DW-1:0] ld, ad;
            logic [DW:0] e1, e2;
            ldv = ($urandom_range(0, 2) == 0); aluv = ($urandom_range(0, 1) == 0);
            la = AW'($urandom_range(0, 3)); aa = AW'($urandom_range(0, 3));
            ld = $urandom; ad = $urandom;
            b1 = AW'($urandom_range(0, 3)); b2 = AW'($urandom_range(0, 3));
            drive(ldv, la, ld, aluv, aa, ad, b1, b2);
            #1;
            full = (mq.size() == DEPTH);
            ldf  = ldv && !full;
            aluf = aluv && !full && !ldv;
            check("rnd_ld_ready", bus.ld_ready, !full);
            check("rnd_alu_ready", bus.alu_ready, !full && !ldv);
            @(posedge clk); #1;
            if (mq.size() > 0) begin
                m_rw = 1; m_a3 = mq[0].a; m_wd = mq[0].d; void'(mq.pop_front());
            end else m_rw = 0;
            if (ldf && la != 0) mq.push_back('{a: la, d: ld});
            else if (aluf && aa != 0) mq.push_back('{a: aa, d: ad});
            check("rnd_count", bus.count, mq.size());
            check("rnd_rw", bus.rw, m_rw);
            if (m_rw) begin
                check("rnd_addr3", bus.addr3, m_a3);
                check("rnd_wdata", bus.wdata, m_wd);
            end
            e1 = m_lookup(b1); e2 = m_lookup(b2);
            check("rnd_byp1", {bus.byp_hit1, bus.byp_data1}, e1);
            check("rnd_byp2", {bus.byp_hit2, bus.byp_data2}, e2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back queue that is the writer side of the register file's single write port (rw, addr3, wdata).
- Accepts results from two producers: the ALU and the load unit. Buffers them in a small in-order FIFO and drains at most one entry per cycle into the register file.
- Provides a combinational bypass lookup so decode can pick up values still queued or in flight to the register file.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- ld_valid  in  1  load result valid
- ld_ready  out  1  load result accepted this cycle
- ld_addr  in  AW  load destination register
- ld_data  in  DW  load data
- rw  out  1  register-file write enable (registered)
- addr3  out  AW  register-file write address (registered)
- wdata  out  DW  register-file write data (registered)
- byp_addr1  in  AW  bypass lookup address, read port 1
- byp_addr2  in  AW  bypass lookup address, read port 2
- byp_hit1  out  1  byp_addr1 matches a pending write
- byp_data1  out  DW  newest pending data for byp_addr1
- byp_hit2  out  1  byp_addr2 matches a pending write
- byp_data2  out  DW  newest pending data for byp_addr2
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async):
  - FIFO pointers and count go to 0.
  - rw=0, addr3=0, wdata=0.
  - Queued contents are discarded; no write is issued after reset releases.
- Accept, at most one producer per cycle, fixed priority load > ALU:
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid.
  - A handshake completes when valid && ready at a rising edge.
- Register 0:
  - A handshake with addr==0 completes normally but is dropped: not enqueued, no rw pulse.
- Drain, at each rising edge:
  - If the FIFO is non-empty: pop the head into rw<=1, addr3<=head.addr, wdata<=head.data.
  - Otherwise rw<=0.
- Latency:
  - Accepted at edge k -> in FIFO after k -> in output regs after k+1 -> register file written at edge k+2 (with an empty queue).
- Occupancy:
  - Enqueue and pop may occur in the same edge; count is unchanged in that case.
  - full = (count==DEPTH). Readiness is based on count before the edge, so a full queue does not accept even while popping.
- Ordering:
  - Strict FIFO; writes reach the register file in acceptance order.
  - Multiple entries to the same register are all written, oldest first.
- Bypass (combinational), search set = valid FIFO entries plus the output register while rw=1:
  - Hit if the address matches and the address is nonzero.
  - Priority is newest first: youngest FIFO entry, then older entries, then the output register.
  - byp_dataN = 0 when there is no hit.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count.

Decomposition:
- Shared package regfile_pkg:
  - constants AW=5, DW=32, REG_ZERO=0
  - typedef wb_entry_t {addr[AW-1:0], data[DW-1:0]}
- One natural sub-module: wb_fifo, a synchronous FIFO of wb_entry_t.
  - Exposes all entries plus a per-slot valid vector so the top can do the bypass search.
- Arbitration, output registers and bypass muxing stay in the top level.

Test Plan:
- Single write: ALU valid, addr=5, data=0xDEADBEEF at edge 0.
  - Required: alu_ready=1; rw=1, addr3=5, wdata=0xDEADBEEF in the cycle after edge 1; rw=0 after edge 2.
  - Required: byp_addr1=5 hits with 0xDEADBEEF from after edge 0 through the cycle before edge 2.
- Contention: ld(addr 3, 0x11) and alu(addr 4, 0x22) both valid at edge 0, ALU held valid.
  - Required: ld_ready=1, alu_ready=0 at edge 0; ALU accepted at edge 1.
  - Required: register-file writes in order 3 then 4.
- Zero register: alu addr=0, data=0x55.
  - Required: handshake completes, count stays 0, rw never asserts, byp_addr1=0 never hits.
- Full: stall drain is impossible, so instead inject 6 back-to-back loads, DEPTH=4.
  - Required: count saturates at 4 only if injected faster than drained; otherwise count ≤1.
  - Required: ld_ready=0 exactly when count==4; no entry lost; 6 writes emitted in order.
- Bypass newest: enqueue addr 7 =0xA, then addr 7 =0xB on consecutive edges.
  - Required: byp_data1=0xB while both are pending; register file receives 0xA then 0xB.
- Reset mid-operation: 3 entries queued, rst_n low asynchronously between edges.
  - Required: rw, count and byp_hit drop to 0 immediately; no writes after release.
